scan_seq_ctrl: RTL and testbench
================================

// Module: scan_seq_ctrl
// PURPOSE
//  Sequences the scan chain of the bit-packing FIFO core: serially loads a test pattern, releases
//  functional clocking for a programmable capture window, serially unloads the chain and compares
//  the result against an expected word. Sits between a test host (start/pattern/expected) and the
//  core's scanIn/scanEnable/scanOut pins; also gates pushin during shift phases.
// PARAMETERS
//  PAT_W    32  max chain length / pattern width handled
//  CNT_W    6   width of length and bit counters (must hold PAT_W)
//  CAP_W    4   width of capture-window cycle count
// PORTS
//  clk          in   1      single clock, all state on rising edge
//  rst          in   1      synchronous, active-low reset
//  start        in   1      1-cycle request; accepted only in IDLE
//  abort        in   1      return to IDLE from any state, no done pulse
//  chain_len    in   CNT_W  bits to shift; sampled at start
//  cap_cycles   in   CAP_W  functional cycles between load and unload; sampled at start
//  pattern      in   PAT_W  load pattern, LSB shifted first; sampled at start
//  expected     in   PAT_W  compare value; sampled at start
//  scan_en      out  1      to core scanEnable (registered)
//  scan_si      out  1      to core scanIn (registered)
//  scan_so      in   1      from core scanOut
//  func_hold    out  1      1 = core must ignore pushin (high in SHIFT_IN/SHIFT_OUT)
//  busy         out  1      1 in any state except IDLE
//  done         out  1      1-cycle pulse at end of sequence
//  pass         out  1      valid with done, held until next start
//  len_err      out  1      valid with done: chain_len was 0
//  captured     out  PAT_W  unloaded bits, bit k = k-th bit out; held until next start
// BEHAVIOUR
//  - Reset (rst=0 at edge): state IDLE; scan_en, scan_si, func_hold, busy, done, pass, len_err = 0;
//    captured = 0. Reset mid-sequence drops scan_en on that same edge.
//  - States: IDLE -> SHIFT_IN -> CAPTURE -> SHIFT_OUT -> DONE -> IDLE.
//  - IDLE: start=1 latches inputs; chain_len > PAT_W clamped to PAT_W. chain_len=0 -> DONE directly
//    with len_err=1, pass=0, scan_en never asserted. start while busy ignored.
//  - SHIFT_IN: exactly L cycles (L = clamped len), scan_en=1, scan_si = pattern[k] in cycle k.
//    First scan_en=1 on the edge after start is sampled (latency 1).
//  - CAPTURE: scan_en=0, scan_si=0, func_hold=0 for cap_cycles cycles; cap_cycles=0 -> skip
//    straight to SHIFT_OUT (no dead cycle).
//  - SHIFT_OUT: L cycles, scan_en=1, scan_si=0; captured[k] <= scan_so at the k-th edge of the
//    state (k=0..L-1); bits >= L of captured are 0.
//  - DONE: 1 cycle, scan_en=0, done=1, pass = (captured[L-1:0] == expected[L-1:0]).
//  - abort=1: next edge -> IDLE, scan_en/func_hold/busy = 0, captured/pass unchanged, no done.
//    abort and start same cycle in IDLE: abort wins. rst overrides abort.
//  - Counters never wrap: bit counter compares to L-1 and reloads on state change.
// STRUCTURE
//  - scan_seq_pkg: state encoding localparams (IDLE, SHIFT_IN, CAPTURE, SHIFT_OUT, DONE),
//    default widths.
//  - Sub-module scan_shreg: PAT_W-bit load/shift register with parallel load of pattern and
//    serial capture of scan_so; FSM and counters stay in scan_seq_ctrl.
// TESTING
//  - Loopback bench: 5-flop shift-register model on scan_si/scan_so, capture leaves data untouched.
//  - len=5, pattern=0x1D, expected=0x1D, cap=1 -> scan_si seq 1,0,1,1,1; scan_en high 5 cycles,
//    low 1, high 5; done with pass=1, captured=0x1D.
//  - same, expected=0x1C -> done with pass=0, captured=0x1D.
//  - len=0, start -> done 1 cycle later, len_err=1, pass=0, scan_en stays 0.
//  - abort in 3rd SHIFT_OUT cycle -> IDLE next edge, scan_en=0, no done; new start runs normally.
//  - rst=0 mid SHIFT_IN -> all outputs 0 on that edge; start during busy ignored; len=40 clamps to 32.

Source files
------------

// File: rtl/scan_seq_pkg.sv
// Shared definitions for the scan-chain sequencer: default widths and state encoding.
package scan_seq_pkg;

    localparam int PAT_W_DEF = 32;
    localparam int CNT_W_DEF = 6;
    localparam int CAP_W_DEF = 4;

    localparam logic [2:0] ST_IDLE      = 3'd0;
    localparam logic [2:0] ST_SHIFT_IN  = 3'd1;
    localparam logic [2:0] ST_CAPTURE   = 3'd2;
    localparam logic [2:0] ST_SHIFT_OUT = 3'd3;
    localparam logic [2:0] ST_DONE      = 3'd4;

    typedef enum logic [2:0] {
        IDLE      = ST_IDLE,
        SHIFT_IN  = ST_SHIFT_IN,
        CAPTURE   = ST_CAPTURE,
        SHIFT_OUT = ST_SHIFT_OUT,
        DONE      = ST_DONE
    } state_t;

endpackage

// File: rtl/scan_shreg.sv
// Pattern load/shift register feeding scanIn, plus the capture register filled from scanOut.
module scan_shreg #(
    parameter int PAT_W = 32,
    parameter int CNT_W = 6
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic             shift,
    input  logic             cap_en,
    input  logic [PAT_W-1:0] pattern,
    input  logic [CNT_W-1:0] idx,
    input  logic             so,
    output logic             si_next,
    output logic [PAT_W-1:0] captured,
    output logic [PAT_W-1:0] cap_next
);

    logic [PAT_W-1:0] pat_q;

    // Bit 0 goes straight to scan_si on load, so the register keeps only the remaining bits.
    assign si_next = load ? pattern[0] : pat_q[0];

    always_comb begin
        cap_next = captured;
        for (int i = 0; i < PAT_W; i++) begin
            if (cap_en && (idx == CNT_W'(i))) begin
                cap_next[i] = so;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (load) begin
            pat_q <= pattern >> 1;
        end else if (shift) begin
            pat_q <= pat_q >> 1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            captured <= '0;
        end else if (load) begin
            captured <= '0;
        end else begin
            captured <= cap_next;
        end
    end

endmodule

// File: rtl/scan_seq_ctrl.sv
// Scan-chain sequencer: shift pattern in, run a functional capture window, shift result out and compare.
module scan_seq_ctrl
    import scan_seq_pkg::*;
#(
    parameter int PAT_W = PAT_W_DEF,
    parameter int CNT_W = CNT_W_DEF,
    parameter int CAP_W = CAP_W_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             abort,
    input  logic [CNT_W-1:0] chain_len,
    input  logic [CAP_W-1:0] cap_cycles,
    input  logic [PAT_W-1:0] pattern,
    input  logic [PAT_W-1:0] expected,
    output logic             scan_en,
    output logic             scan_si,
    input  logic             scan_so,
    output logic             func_hold,
    output logic             busy,
    output logic             done,
    output logic             pass,
    output logic             len_err,
    output logic [PAT_W-1:0] captured
);

    state_t           state, next_state;
    logic [CNT_W-1:0] len_q, bit_cnt, len_clamped;
    logic [CAP_W-1:0] capc_q, cap_cnt;
    logic [PAT_W-1:0] exp_q, cap_next;
    logic             accept, last_bit, last_cap, si_next, shreg_shift, shreg_cap;

    function automatic logic [PAT_W-1:0] len_mask(input logic [CNT_W-1:0] n);
        logic [PAT_W-1:0] m;
        for (int i = 0; i < PAT_W; i++) begin
            m[i] = (CNT_W'(i) < n);
        end
        return m;
    endfunction

    assign len_clamped = (chain_len > CNT_W'(PAT_W)) ? CNT_W'(PAT_W) : chain_len;
    assign accept      = (state == IDLE) && start && !abort;
    assign last_bit    = (bit_cnt == len_q - CNT_W'(1));
    assign last_cap    = (cap_cnt == capc_q - CAP_W'(1));
    assign shreg_shift = (state == SHIFT_IN) && (next_state == SHIFT_IN);
    assign shreg_cap   = (state == SHIFT_OUT) && !abort;

    always_comb begin
        next_state = state;
        busy       = (state != IDLE);
        func_hold  = (state == SHIFT_IN) || (state == SHIFT_OUT);
        done       = (state == DONE);
        case (state)
            IDLE:      if (accept) next_state = (len_clamped == '0) ? DONE : SHIFT_IN;
            SHIFT_IN:  if (last_bit) next_state = (capc_q == '0) ? SHIFT_OUT : CAPTURE;
            CAPTURE:   if (last_cap) next_state = SHIFT_OUT;
            SHIFT_OUT: if (last_bit) next_state = DONE;
            DONE:      next_state = IDLE;
            default:   next_state = IDLE;
        endcase
        if (abort) begin
            next_state = IDLE;
        end
    end

    // scan_en/scan_si are registered from next_state so the core sees them one edge after start.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state   <= IDLE;
            scan_en <= 1'b0;
            scan_si <= 1'b0;
            pass    <= 1'b0;
            len_err <= 1'b0;
            bit_cnt <= '0;
            cap_cnt <= '0;
        end else begin
            state   <= next_state;
            scan_en <= (next_state == SHIFT_IN) || (next_state == SHIFT_OUT);
            scan_si <= (next_state == SHIFT_IN) && si_next;
            if (next_state != state) begin
                bit_cnt <= '0;
                cap_cnt <= '0;
            end else begin
                if ((state == SHIFT_IN) || (state == SHIFT_OUT)) bit_cnt <= bit_cnt + CNT_W'(1);
                if (state == CAPTURE) cap_cnt <= cap_cnt + CAP_W'(1);
            end
            if (accept) begin
                pass    <= 1'b0;
                len_err <= (len_clamped == '0);
            end else if ((state == SHIFT_OUT) && (next_state == DONE)) begin
                pass <= (((cap_next ^ exp_q) & len_mask(len_q)) == '0);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (accept) begin
            len_q  <= len_clamped;
            capc_q <= cap_cycles;
            exp_q  <= expected;
        end
    end

    scan_shreg #(
        .PAT_W (PAT_W),
        .CNT_W (CNT_W)
    ) u_shreg (
        .clk      (clk),
        .rst      (rst),
        .load     (accept),
        .shift    (shreg_shift),
        .cap_en   (shreg_cap),
        .pattern  (pattern),
        .idx      (bit_cnt),
        .so       (scan_so),
        .si_next  (si_next),
        .captured (captured),
        .cap_next (cap_next)
    );

endmodule

// File: tb/tb_scan_seq_ctrl.sv
// Loopback bench: a 5-flop chain models the core; expected traces come from cycle arithmetic.
module tb_scan_seq_ctrl;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        start = 1'b0;
    logic        abort = 1'b0;
    logic [5:0]  chain_len = '0;
    logic [3:0]  cap_cycles = '0;
    logic [31:0] pattern = '0;
    logic [31:0] expected = '0;
    logic        scan_en, scan_si, scan_so, func_hold, busy, done, pass, len_err;
    logic [31:0] captured;
    logic [4:0]  ch = '0;

    int n_checks = 0;
    int n_errors = 0;

    scan_seq_ctrl dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .abort      (abort),
        .chain_len  (chain_len),
        .cap_cycles (cap_cycles),
        .pattern    (pattern),
        .expected   (expected),
        .scan_en    (scan_en),
        .scan_si    (scan_si),
        .scan_so    (scan_so),
        .func_hold  (func_hold),
        .busy       (busy),
        .done       (done),
        .pass       (pass),
        .len_err    (len_err),
        .captured   (captured)
    );

    always #5 clk = ~clk;

    assign scan_so = ch[4];
    always @(posedge clk) if (scan_en) ch <= {ch[3:0], scan_si};

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] low_mask(input int n);
        logic [63:0] m;
        m = (64'd1 << n) - 64'd1;
        return m[31:0];
    endfunction

    // Bit stream through the chain: 5 resident bits, then L pattern bits, then zeros.
    function automatic logic [31:0] model_capture(input logic [4:0] chs, input logic [31:0] pat, input int L);
        logic [31:0] r;
        int j;
        r = '0;
        for (int k = 0; k < L; k++) begin
            j = L + k;
            if (j < 5)          r[k] = chs[4-j];
            else if (j - 5 < L) r[k] = pat[j-5];
            else                r[k] = 1'b0;
        end
        return r;
    endfunction

    task automatic run_seq(input int len_in, input int cap, input logic [31:0] pat,
                           input logic [31:0] expv, input bit match,
                           input int abort_at, input int busy_start_at, input int rst_at);
        int L, total, nb;
        logic [31:0] ecap;
        logic epass;
        logic [4:0] vec;
        L = (len_in > 32) ? 32 : len_in;
        @(negedge clk);
        ecap = model_capture(ch, pat, L);
        if (match) expv = ecap | (expv & ~low_mask(L));
        epass = (L != 0) && ((ecap & low_mask(L)) == (expv & low_mask(L)));
        chain_len = len_in[5:0];
        cap_cycles = cap[3:0];
        pattern = pat;
        expected = expv;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        chain_len = 6'($urandom);
        cap_cycles = 4'($urandom);
        pattern = $urandom;
        expected = $urandom;
        if (L == 0) begin
            check("len0_done", {scan_en, scan_si, func_hold, busy, done, pass, len_err}, 7'b0001101);
            @(negedge clk);
            check("len0_idle", {scan_en, busy, done}, 3'b000);
            return;
        end
        total = 2 * L + cap;
        for (int c = 0; c <= total + 1; c++) begin
            start = 1'b0;
            if (c < L)            vec = {1'b1, pat[c], 3'b110};
            else if (c < L + cap) vec = 5'b00010;
            else if (c < total)   vec = 5'b10110;
            else if (c == total)  vec = 5'b00011;
            else                  vec = 5'b00000;
            check("trace", {scan_en, scan_si, func_hold, busy, done}, vec);
            if (c == total) begin
                check("pass", pass, epass);
                check("len_err", len_err, 1'b0);
                check("captured", captured, ecap);
            end
            if (c == total + 1) check("pass_hold", pass, epass);
            if (c == abort_at) begin
                abort = 1'b1;
                @(negedge clk);
                abort = 1'b0;
                nb = c - (L + cap);
                if (nb < 0) nb = 0;
                if (nb > L) nb = L;
                check("abort_out", {scan_en, func_hold, busy, done, pass}, 5'b00000);
                check("abort_cap", captured, ecap & low_mask(nb));
                @(negedge clk);
                check("abort_nodone", {busy, done}, 2'b00);
                return;
            end
            if (c == rst_at) begin
                rst = 1'b0;
                @(negedge clk);
                check("rst_out", {scan_en, scan_si, func_hold, busy, done, pass, len_err}, 7'b0);
                check("rst_cap", captured, 32'h0);
                rst = 1'b1;
                return;
            end
            if (c == busy_start_at) start = 1'b1;
            @(negedge clk);
        end
        start = 1'b0;
    endtask

    initial begin
        rst = 1'b0;
        repeat (3) @(negedge clk);
        check("reset_out", {scan_en, scan_si, func_hold, busy, done, pass, len_err}, 7'b0);
        check("reset_cap", captured, 32'h0);
        rst = 1'b1;

        run_seq(5, 1, 32'h1D, 32'h1D, 1'b0, -1, -1, -1);
        run_seq(5, 1, 32'h1D, 32'h1C, 1'b0, -1, -1, -1);
        run_seq(0, 3, 32'h1D, 32'h1D, 1'b0, -1, -1, -1);
        run_seq(5, 1, 32'h1D, 32'h1D, 1'b0, 8, -1, -1);
        run_seq(5, 1, 32'h1D, 32'h1D, 1'b0, -1, -1, -1);

        // abort beats start in IDLE
        @(negedge clk);
        chain_len = 6'd5;
        start = 1'b1;
        abort = 1'b1;
        @(negedge clk);
        start = 1'b0;
        abort = 1'b0;
        check("abort_start", {scan_en, busy, done}, 3'b000);

        run_seq(10, 2, $urandom, $urandom, 1'b0, -1, -1, 3);
        run_seq(12, 3, $urandom, $urandom, 1'b1, -1, 5, -1);
        run_seq(40, 2, $urandom, $urandom, 1'b1, -1, -1, -1);
        run_seq(7, 0, $urandom, $urandom, 1'b1, -1, -1, -1);
        run_seq(3, 0, $urandom, $urandom, 1'b0, -1, -1, -1);

        for (int i = 0; i < 20; i++) begin
            run_seq($urandom_range(0, 40), $urandom_range(0, 15), $urandom, $urandom,
                    1'($urandom), -1, -1, -1);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
